// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer of fetched packets with
// valid/ready handshakes on both sides and a NOP bubble presented when empty.
module if_id_queue #(
    parameter int unsigned      AW    = 32,
    parameter int unsigned      DW    = 32,
    parameter int unsigned      DEPTH = 4,
    parameter logic [DW-1:0]    NOP   = DW'(32'h00000013)
) (
    input  logic                         ck_i,
    input  logic                         rs_n_i,
    input  logic                         flush_i,
    input  logic                         branch_redirect_i,
    input  logic                         if_valid_i,
    output logic                         if_ready_o,
    input  logic [AW-1:0]                pc_i,
    input  logic [DW-1:0]                ins_i,
    input  logic [AW-1:0]                next_pc_i,
    input  logic                         next_taken_i,
    input  logic                         branch_slot_end_i,
    output logic                         id_valid_o,
    input  logic                         id_ready_i,
    output logic [AW-1:0]                pc_o,
    output logic [DW-1:0]                ins_o,
    output logic [AW-1:0]                next_pc_o,
    output logic                         next_taken_o,
    output logic                         branch_slot_end_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW-1:0] pc_mem      [DEPTH];
    logic [DW-1:0] ins_mem     [DEPTH];
    logic [AW-1:0] next_pc_mem [DEPTH];
    logic          taken_mem   [DEPTH];
    logic          bse_mem     [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic          discard;

    assign if_ready_o = (cnt != CW'(DEPTH));
    assign id_valid_o = (cnt != '0);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_valid_o & id_ready_i;
    assign discard    = flush_i | branch_redirect_i;
    assign count_o    = cnt;

    always_ff @(posedge ck_i) begin
        if (!rs_n_i || discard) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; only the pointers and occupancy define validity.
    always_ff @(posedge ck_i) begin
        if (rs_n_i && !discard && push) begin
            pc_mem[wp]      <= pc_i;
            ins_mem[wp]     <= ins_i;
            next_pc_mem[wp] <= next_pc_i;
            taken_mem[wp]   <= next_taken_i;
            bse_mem[wp]     <= branch_slot_end_i;
        end
    end

    always_comb begin
        pc_o              = '0;
        ins_o             = NOP;
        next_pc_o         = '0;
        next_taken_o      = 1'b0;
        branch_slot_end_o = 1'b0;
        if (id_valid_o) begin
            pc_o              = pc_mem[rp];
            ins_o             = ins_mem[rp];
            next_pc_o         = next_pc_mem[rp];
            next_taken_o      = taken_mem[rp];
            branch_slot_end_o = bse_mem[rp];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [DW-1:0] NOP = 32'h00000013;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
        logic [AW-1:0] npc;
        logic          tk;
        logic          bse;
    } pkt_t;

    logic          ck = 1'b0;
    logic          rs_n = 1'b0;
    logic          flush = 1'b0;
    logic          redirect = 1'b0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [AW-1:0] pc_in = '0;
    logic [DW-1:0] ins_in = '0;
    logic [AW-1:0] npc_in = '0;
    logic          tk_in = 1'b0;
    logic          bse_in = 1'b0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ins_out;
    logic [AW-1:0] npc_out;
    logic          tk_out;
    logic          bse_out;
    logic [CW-1:0] count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    pkt_t        mq[$];
    bit          last_push;

    if_id_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .ck_i(ck), .rs_n_i(rs_n), .flush_i(flush), .branch_redirect_i(redirect),
        .if_valid_i(if_valid), .if_ready_o(if_ready),
        .pc_i(pc_in), .ins_i(ins_in), .next_pc_i(npc_in),
        .next_taken_i(tk_in), .branch_slot_end_i(bse_in),
        .id_valid_o(id_valid), .id_ready_i(id_ready),
        .pc_o(pc_out), .ins_o(ins_out), .next_pc_o(npc_out),
        .next_taken_o(tk_out), .branch_slot_end_o(bse_out),
        .count_o(count)
    );

    always #5 ck = ~ck;

    task automatic set_pkt(input logic [AW-1:0] pc, input logic [DW-1:0] ins);
        pc_in  = pc;
        ins_in = ins;
        npc_in = pc + 32'd4;
        tk_in  = ins[0];
        bse_in = ins[1];
    endtask

    // Advance one clock and update the reference model from the inputs held over the edge.
    task automatic step();
        bit   do_push, do_pop;
        pkt_t p;
        do_push = if_valid && (mq.size() < DEPTH);
        do_pop  = id_ready && (mq.size() != 0);
        p = '{pc: pc_in, ins: ins_in, npc: npc_in, tk: tk_in, bse: bse_in};
        @(posedge ck);
        #1;
        if (!rs_n || flush || redirect) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(p);
        end
        last_push = do_push && rs_n && !flush && !redirect;
    endtask

    task automatic idle_inputs();
        flush = 0; redirect = 0; if_valid = 0; id_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs_n = 0;
        step(); step();
        rs_n = 1;
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", id_valid); end
        n_checks++; if (ins_out !== 32'h00000013) begin n_fail++; $display("FAIL reset_ins got=%h want=00000013", ins_out); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", if_ready); end
        n_checks++; if ({pc_out, npc_out, tk_out, bse_out} !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%b/%b want=0", pc_out, npc_out, tk_out, bse_out); end
    endtask

    task automatic test_pass_through();
        idle_inputs();
        id_ready = 1; if_valid = 1;
        set_pkt(32'h80000000, 32'h00500093);
        step();
        if_valid = 0;
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid got=%b want=1", id_valid); end
        n_checks++; if (pc_out !== 32'h80000000) begin n_fail++; $display("FAIL pt_pc got=%h want=80000000", pc_out); end
        n_checks++; if (ins_out !== 32'h00500093) begin n_fail++; $display("FAIL pt_ins got=%h want=00500093", ins_out); end
        n_checks++; if (npc_out !== 32'h80000004) begin n_fail++; $display("FAIL pt_npc got=%h want=80000004", npc_out); end
        step();
        n_checks++; if (id_valid !== 1'b0 || ins_out !== NOP) begin n_fail++; $display("FAIL pt_empty got=%b/%h want=0/%h", id_valid, ins_out, NOP); end
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] popped[$];
        logic [AW-1:0] exp_order[5];
        bit            sent16;
        exp_order = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
        idle_inputs();
        if_valid = 1;
        for (int i = 0; i < 4; i++) begin
            set_pkt(32'(i * 4), 32'h1000 + 32'(i));
            step();
        end
        set_pkt(32'd16, 32'h1004);
        n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_count got=%0d want=4", count); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b want=0", if_ready); end
        step();
        n_checks++; if (count !== CW'(4) || pc_out !== 32'd0) begin n_fail++; $display("FAIL fill_held got=%0d/%h want=4/0", count, pc_out); end
        id_ready = 1;
        sent16 = 0;
        for (int c = 0; c < 20 && popped.size() < 5; c++) begin
            if (id_valid) popped.push_back(pc_out);
            step();
            if (last_push) begin sent16 = 1; if_valid = 0; end
        end
        n_checks++; if (popped.size() != 5 || !sent16) begin n_fail++; $display("FAIL drain_len got=%0d want=5", popped.size()); end
        for (int i = 0; i < 5 && i < popped.size(); i++) begin
            n_checks++; if (popped[i] !== exp_order[i]) begin n_fail++; $display("FAIL drain_order[%0d] got=%h want=%h", i, popped[i], exp_order[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_concurrent();
        idle_inputs();
        flush = 1; step(); flush = 0;
        if_valid = 1;
        for (int i = 0; i < 2; i++) begin set_pkt(32'h200 + 32'(i*4), $urandom); step(); end
        id_ready = 1;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (pc_out !== mq[0].pc || ins_out !== mq[0].ins) begin n_fail++; $display("FAIL cc_head[%0d] got=%h/%h want=%h/%h", i, pc_out, ins_out, mq[0].pc, mq[0].ins); end
            set_pkt(32'h300 + 32'(i*4), $urandom);
            step();
            n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL cc_count[%0d] got=%0d want=2", i, count); end
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        idle_inputs();
        flush = 1; step(); flush = 0;
        if_valid = 1;
        for (int i = 0; i < 3; i++) begin set_pkt(32'h40 + 32'(i*4), $urandom); step(); end
        redirect = 1;
        set_pkt(32'h100, 32'h00000073);
        step();
        idle_inputs();
        n_checks++; if (count !== '0 || ins_out !== NOP || id_valid !== 1'b0) begin n_fail++; $display("FAIL redirect got=%0d/%h/%b want=0/%h/0", count, ins_out, id_valid, NOP); end
        id_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (id_valid !== 1'b0 || pc_out === 32'h100) begin n_fail++; $display("FAIL redirect_leak[%0d] got=%b/%h want=0/0", i, id_valid, pc_out); end
        end
        if_valid = 1; set_pkt(32'h500, 32'h11);
        step();
        if_valid = 0;
        n_checks++; if (id_valid !== 1'b1 || pc_out !== 32'h500) begin n_fail++; $display("FAIL post_redirect got=%b/%h want=1/500", id_valid, pc_out); end
        step();
    endtask

    task automatic test_reset_override();
        idle_inputs();
        if_valid = 1;
        for (int i = 0; i < 4; i++) begin set_pkt(32'h600 + 32'(i*4), $urandom); step(); end
        n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL ro_full got=%0d want=4", count); end
        rs_n = 0; flush = 1;
        step();
        rs_n = 1; idle_inputs();
        n_checks++; if (count !== '0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL ro_reset got=%0d/%b want=0/1", count, if_ready); end
    endtask

    task automatic test_random();
        pkt_t e;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            if_valid = ($urandom_range(0, 99) < 70);
            id_ready = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 99) < 3);
            redirect = ($urandom_range(0, 99) < 3);
            rs_n     = ($urandom_range(0, 199) != 0);
            pc_in = $urandom; ins_in = $urandom; npc_in = $urandom;
            tk_in = 1'($urandom); bse_in = 1'($urandom);
            n_checks++; if (if_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, if_ready, mq.size() < DEPTH); end
            step();
            e = '{pc: '0, ins: NOP, npc: '0, tk: 1'b0, bse: 1'b0};
            if (mq.size() != 0) e = mq[0];
            n_checks++; if (count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", c, count, mq.size()); end
            n_checks++; if (id_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, id_valid, mq.size() != 0); end
            n_checks++;
            if ({pc_out, ins_out, npc_out, tk_out, bse_out} !== e) begin
                n_fail++;
                $display("FAIL rnd_head[%0d] got=%h/%h/%h/%b/%b want=%h/%h/%h/%b/%b", c,
                         pc_out, ins_out, npc_out, tk_out, bse_out, e.pc, e.ins, e.npc, e.tk, e.bse);
            end
        end
        idle_inputs();
        rs_n = 1;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_concurrent();
        test_redirect();
        test_reset_override();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
